// File: rtl/mux_serializer_pkg.sv
// Shared types and constants for the mux-driven serializer.
package mux_ser_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;
    localparam int LEN_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Requested length mapped to 1..WIDTH: zero means a full word, oversize clamps.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(WIDTH))
            return LEN_W'(WIDTH);
        return len;
    endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// Load handshake and serial stream bundle between producer, serializer and consumer.
interface mux_serializer_if;

    logic                           load_valid;
    logic                           load_ready;
    logic [mux_ser_pkg::WIDTH-1:0]  load_data;
    logic [mux_ser_pkg::LEN_W-1:0]  load_len;
    logic                           abort;
    logic                           ser_bit;
    logic                           ser_valid;
    logic                           ser_ready;
    logic                           ser_last;
    logic                           busy;

    // Environment side: produces words, consumes bits.
    modport master (
        output load_valid, load_data, load_len, abort, ser_ready,
        input  load_ready, ser_bit, ser_valid, ser_last, busy
    );

    // Serializer side.
    modport slave (
        input  load_valid, load_data, load_len, abort, ser_ready,
        output load_ready, ser_bit, ser_valid, ser_last, busy
    );

endinterface

// File: rtl/mux_serializer_mux.sv
// Existing 16:1 bit selector; purely combinational.
module mux #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_serializer.sv
// Holds a word on the mux input and walks the select, emitting one bit per beat.
module mux_serializer
    import mux_ser_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_serializer_if.slave bus
);

    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_word;
    logic [SEL_W-1:0]   r_sel;
    logic [LEN_W-1:0]   r_cnt;

    logic               w_send;
    logic               w_last;
    logic               w_beat;
    logic               w_final;
    logic               w_load_ready;
    logic               w_load;
    logic [LEN_W-1:0]   w_len_m1;
    logic               w_ser_bit;

    assign w_send       = (r_state == SEND);
    assign w_last       = w_send && (r_cnt == '0);
    // An abort swallows the beat, so nothing downstream of it may advance.
    assign w_beat       = w_send && bus.ser_ready && !bus.abort;
    assign w_final      = w_beat && w_last;
    assign w_load_ready = !w_send || w_final;
    assign w_load       = bus.load_valid && w_load_ready;
    assign w_len_m1     = eff_len(bus.load_len) - CNT_ONE;

    // Word/select/count registers and the IDLE/SEND state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            // Covers both a load from IDLE and a gapless reload on the final beat.
            r_state <= SEND;
            r_word  <= bus.load_data;
            r_cnt   <= w_len_m1;
            r_sel   <= MSB_FIRST ? w_len_m1[SEL_W-1:0] : '0;
        end else if (w_send && bus.abort) begin
            r_state <= IDLE;
        end else if (w_final) begin
            // Leave the select where it is so it never steps past the word.
            r_state <= IDLE;
        end else if (w_beat) begin
            r_cnt <= r_cnt - CNT_ONE;
            r_sel <= MSB_FIRST ? (r_sel - SEL_ONE) : (r_sel + SEL_ONE);
        end
    end

    mux #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .in  (r_word),
        .sel (r_sel),
        .out (w_ser_bit)
    );

    assign bus.ser_bit    = w_ser_bit;
    assign bus.ser_valid  = w_send;
    assign bus.ser_last   = w_last;
    assign bus.busy       = w_send;
    assign bus.load_ready = w_load_ready;

endmodule
